// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank sequencer.
// Contents: default widths, command op encodings, sequencer state enum,
// and the grant-owner encoding used by the arbiter and the response path.
package regbank_pkg;

    localparam int WORD_SIZE_DEF     = 32;
    localparam int REG_ADDR_SIZE_DEF = 5;
    localparam int IMM_WIDTH_DEF     = 20;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_MOVE  = 2'd2,
        OP_LOADI = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Grant owner / last_grant encoding.
    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

endpackage

// File: rtl/regbank_sequencer_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter.
// Ports:
//   clock, reset  - clock, synchronous active-high reset
//   req[1:0]      - request vector, bit 0 = cpu, bit 1 = host
//   accept        - the current grant is taken this cycle; updates last_grant
//   grant[1:0]    - one-hot grant (all zero when nothing requests)
//   last_grant    - owner of the most recently accepted grant
// On a tie the requester that was not granted last wins. After reset the
// host counts as last granted, so the cpu wins the first tie.
module rr_arbiter2
    import regbank_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       last_grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == OWNER_HOST) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= OWNER_HOST;
        end else if (accept && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/regbank_sequencer.sv
// regbank_sequencer: arbitrates register commands from the cpu and host ports
// and drives the 32x32 register bank with a fixed IDLE/ISSUE/SETTLE/RESP
// sequence, returning READ data (or a zero-data ack) to the issuing port.
// Ports:
//   clock, reset                    - clock, synchronous active-high reset
//   cpu_*/host_* req_valid/ready    - command handshake
//   cpu_*/host_* req_op/rs/rt/rd/data - command fields
//   cpu_*/host_* resp_valid/ready   - response handshake
//   cpu_*/host_* resp_rs/rt_data    - READ data, 0 for other ops
//   bank_*_address, bank_data_in    - bank address/data, held between commands
//   bank_load/store/load_reg_i/load_rd_i - one-hot bank strobes (ISSUE only)
//   bank_rs_data_out, bank_rt_data_out   - bank read data
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a request; winner gets req_ready and is latched
// ST_ISSUE  | exactly one bank strobe asserted for the latched op
// ST_SETTLE | strobes low; READ data captured, otherwise response cleared
// ST_RESP   | resp_valid to the owner until it takes the response
module regbank_sequencer
    import regbank_pkg::*;
#(
    parameter int WORD_SIZE     = WORD_SIZE_DEF,
    parameter int REG_ADDR_SIZE = REG_ADDR_SIZE_DEF,
    parameter int IMM_WIDTH     = IMM_WIDTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_req_valid,
    output logic                     cpu_req_ready,
    input  logic [1:0]               cpu_req_op,
    input  logic [REG_ADDR_SIZE-1:0] cpu_req_rs,
    input  logic [REG_ADDR_SIZE-1:0] cpu_req_rt,
    input  logic [REG_ADDR_SIZE-1:0] cpu_req_rd,
    input  logic [WORD_SIZE-1:0]     cpu_req_data,
    output logic                     cpu_resp_valid,
    input  logic                     cpu_resp_ready,
    output logic [WORD_SIZE-1:0]     cpu_resp_rs_data,
    output logic [WORD_SIZE-1:0]     cpu_resp_rt_data,
    input  logic                     host_req_valid,
    output logic                     host_req_ready,
    input  logic [1:0]               host_req_op,
    input  logic [REG_ADDR_SIZE-1:0] host_req_rs,
    input  logic [REG_ADDR_SIZE-1:0] host_req_rt,
    input  logic [REG_ADDR_SIZE-1:0] host_req_rd,
    input  logic [WORD_SIZE-1:0]     host_req_data,
    output logic                     host_resp_valid,
    input  logic                     host_resp_ready,
    output logic [WORD_SIZE-1:0]     host_resp_rs_data,
    output logic [WORD_SIZE-1:0]     host_resp_rt_data,
    output logic [REG_ADDR_SIZE-1:0] bank_rs_address,
    output logic [REG_ADDR_SIZE-1:0] bank_rt_address,
    output logic [REG_ADDR_SIZE-1:0] bank_rd_address,
    output logic [WORD_SIZE-1:0]     bank_data_in,
    output logic                     bank_load,
    output logic                     bank_store,
    output logic                     bank_load_reg_i,
    output logic                     bank_load_rd_i,
    input  logic [WORD_SIZE-1:0]     bank_rs_data_out,
    input  logic [WORD_SIZE-1:0]     bank_rt_data_out
);

    state_e                   state_q, state_d;
    op_e                      op_q;
    logic                     owner_q;
    logic [WORD_SIZE-1:0]     resp_rs_q, resp_rt_q;

    logic [1:0]               grant;
    logic                     last_grant;
    logic                     accept;

    op_e                      sel_op;
    logic [REG_ADDR_SIZE-1:0] sel_rs, sel_rt, sel_rd;
    logic [WORD_SIZE-1:0]     sel_data, sel_bank_data;

    assign accept = (state_q == ST_IDLE) && (cpu_req_valid || host_req_valid);

    rr_arbiter2 u_arb (
        .clock      (clock),
        .reset      (reset),
        .req        ({host_req_valid, cpu_req_valid}),
        .accept     (accept),
        .grant      (grant),
        .last_grant (last_grant)
    );

    // Command fields of the current winner.
    always_comb begin
        sel_op   = op_e'(grant[1] ? host_req_op : cpu_req_op);
        sel_rs   = grant[1] ? host_req_rs   : cpu_req_rs;
        sel_rt   = grant[1] ? host_req_rt   : cpu_req_rt;
        sel_rd   = grant[1] ? host_req_rd   : cpu_req_rd;
        sel_data = grant[1] ? host_req_data : cpu_req_data;
        // LOADI only carries an IMM_WIDTH immediate; upper bits forced to 0.
        sel_bank_data = sel_data;
        if (sel_op == OP_LOADI) begin
            sel_bank_data = {{(WORD_SIZE-IMM_WIDTH){1'b0}}, sel_data[IMM_WIDTH-1:0]};
        end
    end

    // Bank address/data are loaded at acceptance so they are already stable
    // in ISSUE and stay put through SETTLE and until the next command.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            op_q            <= OP_READ;
            owner_q         <= OWNER_CPU;
            bank_rs_address <= '0;
            bank_rt_address <= '0;
            bank_rd_address <= '0;
            bank_data_in    <= '0;
            resp_rs_q       <= '0;
            resp_rt_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q            <= sel_op;
                owner_q         <= grant[1];
                bank_rs_address <= sel_rs;
                bank_rt_address <= sel_rt;
                bank_rd_address <= sel_rd;
                bank_data_in    <= sel_bank_data;
            end
            if (state_q == ST_SETTLE) begin
                if (op_q == OP_READ) begin
                    resp_rs_q <= bank_rs_data_out;
                    resp_rt_q <= bank_rt_data_out;
                end else begin
                    resp_rs_q <= '0;
                    resp_rt_q <= '0;
                end
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        cpu_req_ready   = 1'b0;
        host_req_ready  = 1'b0;
        cpu_resp_valid  = 1'b0;
        host_resp_valid = 1'b0;
        bank_load       = 1'b0;
        bank_store      = 1'b0;
        bank_load_reg_i = 1'b0;
        bank_load_rd_i  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cpu_req_ready  = grant[0];
                host_req_ready = grant[1];
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (op_q)
                    OP_READ:  bank_load       = 1'b1;
                    OP_WRITE: bank_store      = 1'b1;
                    OP_MOVE:  bank_load_reg_i = 1'b1;
                    OP_LOADI: bank_load_rd_i  = 1'b1;
                    default:  bank_load       = 1'b0;
                endcase
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                cpu_resp_valid  = (owner_q == OWNER_CPU);
                host_resp_valid = (owner_q == OWNER_HOST);
                if ((owner_q == OWNER_CPU  && cpu_resp_ready) ||
                    (owner_q == OWNER_HOST && host_resp_ready)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One shared response register pair; resp_valid tells which port owns it.
    assign cpu_resp_rs_data  = resp_rs_q;
    assign cpu_resp_rt_data  = resp_rt_q;
    assign host_resp_rs_data = resp_rs_q;
    assign host_resp_rt_data = resp_rt_q;

endmodule

// File: tb/tb_regbank_sequencer.sv
// Bench for regbank_sequencer: a simple 32x32 bank model drives the bank
// inputs; a transaction-level model (current command + cycles since
// acceptance) predicts every DUT output each cycle.
module tb_regbank_sequencer;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] data;
    } cmd_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req_valid, cpu_req_ready, cpu_resp_valid, cpu_resp_ready;
    logic [1:0]  cpu_req_op;
    logic [4:0]  cpu_req_rs, cpu_req_rt, cpu_req_rd;
    logic [31:0] cpu_req_data, cpu_resp_rs_data, cpu_resp_rt_data;
    logic        host_req_valid, host_req_ready, host_resp_valid, host_resp_ready;
    logic [1:0]  host_req_op;
    logic [4:0]  host_req_rs, host_req_rt, host_req_rd;
    logic [31:0] host_req_data, host_resp_rs_data, host_resp_rt_data;
    logic [4:0]  bank_rs_address, bank_rt_address, bank_rd_address;
    logic [31:0] bank_data_in, bank_rs_data_out, bank_rt_data_out;
    logic        bank_load, bank_store, bank_load_reg_i, bank_load_rd_i;

    always #5 clock = ~clock;

    regbank_sequencer dut (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_op(cpu_req_op), .cpu_req_rs(cpu_req_rs), .cpu_req_rt(cpu_req_rt),
        .cpu_req_rd(cpu_req_rd), .cpu_req_data(cpu_req_data),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready),
        .cpu_resp_rs_data(cpu_resp_rs_data), .cpu_resp_rt_data(cpu_resp_rt_data),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_op(host_req_op), .host_req_rs(host_req_rs), .host_req_rt(host_req_rt),
        .host_req_rd(host_req_rd), .host_req_data(host_req_data),
        .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
        .host_resp_rs_data(host_resp_rs_data), .host_resp_rt_data(host_resp_rt_data),
        .bank_rs_address(bank_rs_address), .bank_rt_address(bank_rt_address),
        .bank_rd_address(bank_rd_address), .bank_data_in(bank_data_in),
        .bank_load(bank_load), .bank_store(bank_store),
        .bank_load_reg_i(bank_load_reg_i), .bank_load_rd_i(bank_load_rd_i),
        .bank_rs_data_out(bank_rs_data_out), .bank_rt_data_out(bank_rt_data_out)
    );

    // Bank: combinational read; store/load_rd_i write data_in to rd,
    // load_reg_i copies reg[rt] into reg[rs].
    logic [31:0] bank_mem [32];
    logic [31:0] init_val [32];
    logic        bank_init = 1'b1;
    assign bank_rs_data_out = bank_mem[bank_rs_address];
    assign bank_rt_data_out = bank_mem[bank_rt_address];
    always @(posedge clock) begin
        if (bank_init) begin
            for (int i = 0; i < 32; i++) bank_mem[i] <= init_val[i];
        end else begin
            if (bank_store || bank_load_rd_i) bank_mem[bank_rd_address] <= bank_data_in;
            if (bank_load_reg_i) bank_mem[bank_rs_address] <= bank_mem[bank_rt_address];
        end
    end

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Stimulus state
    cmd_t q_cpu[$], q_host[$];
    bit   pres_cpu = 0, pres_host = 0;
    bit   gate_all = 1;
    int   cpu_rr_mode = 1, host_rr_mode = 1;   // 0 low, 1 high, 2 random
    bit   random_fill = 0;

    // Model state
    bit          m_busy = 0;
    int          m_phase = 0;   // cycles since acceptance, saturating at 3
    cmd_t        m_cmd;
    bit          m_owner = 0;
    bit          m_last = 1;    // 1 = host
    logic [4:0]  e_rs = 0, e_rt = 0, e_rd = 0;
    logic [31:0] e_din = 0, m_resp_rs = 0, m_resp_rt = 0;
    logic [31:0] m_regs [32];
    bit          acc_cpu, acc_host, dut_acc_cpu, dut_acc_host;
    int          grant_order[$];

    function automatic int winner(bit c, bit h, bit last);
        if (c && h) return last ? 0 : 1;
        if (c) return 0;
        if (h) return 1;
        return -1;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.op   = 2'($urandom_range(0, 3));
        c.rs   = 5'($urandom_range(0, 31));
        c.rt   = 5'($urandom_range(0, 31));
        c.rd   = 5'($urandom_range(0, 31));
        c.data = $urandom;
        return c;
    endfunction

    function automatic cmd_t mk(logic [1:0] op, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic [31:0] data);
        cmd_t c;
        c.op = op; c.rs = rs; c.rt = rt; c.rd = rd; c.data = data;
        return c;
    endfunction

    task automatic refresh();
        cmd_t c;
        if (random_fill) begin
            if (q_cpu.size() == 0 && $urandom_range(0, 3) == 0) q_cpu.push_back(rand_cmd());
            if (q_host.size() == 0 && $urandom_range(0, 3) == 0) q_host.push_back(rand_cmd());
        end
        if (!pres_cpu && q_cpu.size() > 0 && (gate_all || $urandom_range(0, 2) != 0)) pres_cpu = 1;
        if (!pres_host && q_host.size() > 0 && (gate_all || $urandom_range(0, 2) != 0)) pres_host = 1;
        c = pres_cpu ? q_cpu[0] : '0;
        cpu_req_valid = pres_cpu;
        cpu_req_op = c.op; cpu_req_rs = c.rs; cpu_req_rt = c.rt; cpu_req_rd = c.rd;
        cpu_req_data = c.data;
        c = pres_host ? q_host[0] : '0;
        host_req_valid = pres_host;
        host_req_op = c.op; host_req_rs = c.rs; host_req_rt = c.rt; host_req_rd = c.rd;
        host_req_data = c.data;
        cpu_resp_ready  = (cpu_rr_mode == 2)  ? 1'($urandom_range(0, 1)) : (cpu_rr_mode == 1);
        host_resp_ready = (host_rr_mode == 2) ? 1'($urandom_range(0, 1)) : (host_rr_mode == 1);
    endtask

    task automatic check_outputs();
        logic ec, eh, el, es, elr, eld, ecv, ehv;
        int w;
        ec = 0; eh = 0; el = 0; es = 0; elr = 0; eld = 0; ecv = 0; ehv = 0;
        if (!m_busy) begin
            w = winner(pres_cpu, pres_host, m_last);
            ec = (w == 0);
            eh = (w == 1);
        end else if (m_phase == 1) begin
            case (m_cmd.op)
                2'd0: el = 1;
                2'd1: es = 1;
                2'd2: elr = 1;
                default: eld = 1;
            endcase
        end else if (m_phase >= 3) begin
            ecv = !m_owner;
            ehv = m_owner;
        end
        chk("cpu_req_ready", cpu_req_ready, ec);
        chk("host_req_ready", host_req_ready, eh);
        chk("cpu_resp_valid", cpu_resp_valid, ecv);
        chk("host_resp_valid", host_resp_valid, ehv);
        chk("bank_load", bank_load, el);
        chk("bank_store", bank_store, es);
        chk("bank_load_reg_i", bank_load_reg_i, elr);
        chk("bank_load_rd_i", bank_load_rd_i, eld);
        chk("strobe_onehot",
            32'($countones({bank_load, bank_store, bank_load_reg_i, bank_load_rd_i}) <= 1), 1);
        chk("bank_rs_address", bank_rs_address, e_rs);
        chk("bank_rt_address", bank_rt_address, e_rt);
        chk("bank_rd_address", bank_rd_address, e_rd);
        chk("bank_data_in", bank_data_in, e_din);
        if (ecv) begin
            chk("cpu_resp_rs_data", cpu_resp_rs_data, m_resp_rs);
            chk("cpu_resp_rt_data", cpu_resp_rt_data, m_resp_rt);
        end
        if (ehv) begin
            chk("host_resp_rs_data", host_resp_rs_data, m_resp_rs);
            chk("host_resp_rt_data", host_resp_rt_data, m_resp_rt);
        end
    endtask

    task automatic model_update();
        int w;
        acc_cpu = 0; acc_host = 0;
        // The bank sees the ISSUE strobe at this edge even if reset is high.
        if (m_busy && m_phase == 1 && !bank_init) begin
            case (m_cmd.op)
                2'd1: m_regs[m_cmd.rd] = m_cmd.data;
                2'd2: m_regs[m_cmd.rs] = m_regs[m_cmd.rt];
                2'd3: m_regs[m_cmd.rd] = {12'b0, m_cmd.data[19:0]};
                default: ;
            endcase
        end
        if (reset) begin
            m_busy = 0; m_phase = 0; m_last = 1;
            e_rs = 0; e_rt = 0; e_rd = 0; e_din = 0; m_resp_rs = 0; m_resp_rt = 0;
        end else if (!m_busy) begin
            w = winner(pres_cpu, pres_host, m_last);
            if (w >= 0) begin
                m_cmd = (w == 1) ? q_host[0] : q_cpu[0];
                m_owner = (w == 1);
                m_last = (w == 1);
                m_busy = 1; m_phase = 1;
                e_rs = m_cmd.rs; e_rt = m_cmd.rt; e_rd = m_cmd.rd;
                e_din = (m_cmd.op == 2'd3) ? {12'b0, m_cmd.data[19:0]} : m_cmd.data;
                acc_cpu = (w == 0); acc_host = (w == 1);
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_resp_rs = (m_cmd.op == 2'd0) ? m_regs[m_cmd.rs] : 32'h0;
            m_resp_rt = (m_cmd.op == 2'd0) ? m_regs[m_cmd.rt] : 32'h0;
            m_phase = 3;
        end else if ((m_owner && host_resp_ready) || (!m_owner && cpu_resp_ready)) begin
            m_busy = 0; m_phase = 0;
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_outputs();
        dut_acc_cpu  = cpu_req_valid && cpu_req_ready;
        dut_acc_host = host_req_valid && host_req_ready;
        if (dut_acc_cpu) grant_order.push_back(0);
        if (dut_acc_host) grant_order.push_back(1);
        @(posedge clock);
        model_update();
        #1;
        if (acc_cpu) begin void'(q_cpu.pop_front()); pres_cpu = 0; end
        if (acc_host) begin void'(q_host.pop_front()); pres_host = 0; end
        refresh();
    endtask

    task automatic wait_accept(bit host, string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(host ? dut_acc_host : dut_acc_cpu) && n < 50);
        chk({name, "_accept_timeout"}, host ? dut_acc_host : dut_acc_cpu, 1);
    endtask

    task automatic wait_resp(bit host, string name);
        int n = 0;
        while (!(host ? host_resp_valid : cpu_resp_valid) && n < 50) begin
            step();
            n++;
        end
        chk({name, "_resp_timeout"}, host ? host_resp_valid : cpu_resp_valid, 1);
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((m_busy || pres_cpu || pres_host) && n < 200) begin
            step();
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(m_busy || pres_cpu || pres_host), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            init_val[i] = $urandom;
            m_regs[i] = init_val[i];
        end
        refresh();
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) step();
        bank_init = 0;
        reset = 0;
        refresh();
        step();
        // Reset state, idle with no requests
        chk("rst_cpu_req_ready", cpu_req_ready, 0);
        chk("rst_cpu_resp_valid", cpu_resp_valid, 0);
        chk("rst_host_resp_valid", host_resp_valid, 0);
        chk("rst_bank_data_in", bank_data_in, 0);
        chk("rst_bank_rd_address", bank_rd_address, 0);
        chk("rst_cpu_resp_rs_data", cpu_resp_rs_data, 0);
        chk("rst_host_resp_rt_data", host_resp_rt_data, 0);

        // First tie goes to the cpu: cpu WRITE vs host READ
        q_cpu.push_back(mk(2'd1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF));
        q_host.push_back(mk(2'd0, 5'd5, 5'd0, 5'd0, 32'h0));
        refresh();
        wait_accept(0, "write");
        chk("tie_host_not_first", 32'(dut_acc_host), 0);
        chk("write_store_issue", bank_store, 1);
        chk("write_rd_addr", bank_rd_address, 5);
        step();
        chk("write_store_settle", bank_store, 0);
        step();
        chk("write_resp_valid", cpu_resp_valid, 1);
        chk("write_resp_data", cpu_resp_rs_data, 0);
        wait_resp(1, "read");
        chk("read_rs_data", host_resp_rs_data, 32'hDEADBEEF);
        chk("read_rt_data", host_resp_rt_data, init_val[0]);
        drain("rw");

        // LOADI then MOVE
        q_cpu.push_back(mk(2'd3, 5'd0, 5'd0, 5'd7, 32'hFFFFFFFF));
        refresh();
        wait_accept(0, "loadi");
        chk("loadi_data_in", bank_data_in, 32'h000FFFFF);
        chk("loadi_strobe", bank_load_rd_i, 1);
        step();
        chk("loadi_strobe_off", bank_load_rd_i, 0);
        drain("loadi");
        q_host.push_back(mk(2'd2, 5'd3, 5'd7, 5'd0, 32'h0));
        refresh();
        wait_accept(1, "move");
        chk("move_strobe", bank_load_reg_i, 1);
        chk("move_rs_addr", bank_rs_address, 3);
        chk("move_rt_addr", bank_rt_address, 7);
        drain("move");
        chk("model_move_pin", m_regs[3], 32'h000FFFFF);

        // Both requesters valid for 8 commands: strict alternation from cpu
        for (int i = 0; i < 4; i++) begin
            q_cpu.push_back(rand_cmd());
            q_host.push_back(rand_cmd());
        end
        grant_order.delete();
        refresh();
        drain("alt");
        chk("alt_count", grant_order.size(), 8);
        for (int i = 0; i < grant_order.size() && i < 8; i++)
            chk($sformatf("alt_grant_%0d", i), grant_order[i], i % 2);

        // Response back-pressure for 5 cycles while the host waits
        cpu_rr_mode = 0;
        q_cpu.push_back(mk(2'd0, 5'd5, 5'd3, 5'd0, 32'h0));
        refresh();
        wait_accept(0, "stall");
        q_host.push_back(mk(2'd1, 5'd0, 5'd0, 5'd12, 32'h0BADF00D));
        refresh();
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp_valid", cpu_resp_valid, 1);
            chk("stall_rs_data", cpu_resp_rs_data, 32'hDEADBEEF);
            chk("stall_host_ready", host_req_ready, 0);
            step();
        end
        cpu_rr_mode = 1;
        refresh();
        wait_accept(1, "after_stall");
        drain("stall");

        // Reset during ISSUE of a WRITE
        q_cpu.push_back(mk(2'd1, 5'd0, 5'd0, 5'd9, 32'h12345678));
        refresh();
        wait_accept(0, "rst_write");
        chk("rst_write_strobe", bank_store, 1);
        reset = 1;
        step();
        chk("rst_strobe_low", bank_store, 0);
        chk("rst_no_resp", cpu_resp_valid, 0);
        chk("rst_addr_cleared", bank_rd_address, 0);
        reset = 0;
        q_host.push_back(mk(2'd0, 5'd9, 5'd1, 5'd0, 32'h0));
        refresh();
        step();
        chk("rst_next_accept", dut_acc_host, 1);
        drain("rst");

        // Randomized traffic
        gate_all = 0;
        random_fill = 1;
        cpu_rr_mode = 2;
        host_rr_mode = 2;
        refresh();
        for (int i = 0; i < 600; i++) step();
        random_fill = 0;
        cpu_rr_mode = 1;
        host_rr_mode = 1;
        gate_all = 1;
        refresh();
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_sequencer.md
# regbank_sequencer

Sequencer and two-port arbiter in front of the 32×32 register bank. Accepts register commands (READ, WRITE, MOVE, LOADI) from the CPU control path and from the host/debug port. Grants one command at a time by round robin and drives the bank's address, data and one-hot strobes (load, store, load_reg_i, load_rd_i) with a fixed cycle sequence. Returns read data or a completion ack to the requester that issued the command.

## Interface
Parameters:
- WORD_SIZE, 32, data width; matches the bank
- REG_ADDR_SIZE, 5, register address width
- IMM_WIDTH, 20, LOADI immediate width; upper bits are forced to 0

Ports (`<p>` is `cpu` or `host`; each port set exists twice):
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- `<p>`_req_valid  in  1  command present
- `<p>`_req_ready  out  1  command accepted this cycle when valid & ready
- `<p>`_req_op  in  2  command: 0 READ, 1 WRITE, 2 MOVE, 3 LOADI
- `<p>`_req_rs, `<p>`_req_rt, `<p>`_req_rd  in  REG_ADDR_SIZE each  register addresses
- `<p>`_req_data  in  WORD_SIZE  write or immediate data
- `<p>`_resp_valid  out  1  response pending
- `<p>`_resp_ready  in  1  response consumed when valid & ready
- `<p>`_resp_rs_data, `<p>`_resp_rt_data  out  WORD_SIZE each  READ data; 0 for all other ops
- bank_rs_address, bank_rt_address, bank_rd_address  out  REG_ADDR_SIZE each
- bank_data_in  out  WORD_SIZE
- bank_load, bank_store, bank_load_reg_i, bank_load_rd_i  out  1 each  bank strobes
- bank_rs_data_out, bank_rt_data_out  in  WORD_SIZE each

## Operation
- FSM states: IDLE, ISSUE, SETTLE, RESP.
- IDLE: if any req_valid, arbitrate. Assert req_ready to the winner only, for one cycle. Latch its op, addresses and data, and record the grant owner. Go to ISSUE.
- ISSUE: assert exactly one strobe for one cycle:
  - READ → bank_load
  - WRITE → bank_store
  - MOVE → bank_load_reg_i; bank_rs_address is the destination, bank_rt_address the source
  - LOADI → bank_load_rd_i, with bank_data_in = {zeros, data[IMM_WIDTH-1:0]}
  - Go to SETTLE.
- SETTLE: all strobes low. Addresses and data are held unchanged from ISSUE. For READ, capture bank_rs_data_out/bank_rt_data_out into response registers; for other ops, clear the response registers to 0. Go to RESP.
- RESP: assert resp_valid only to the grant owner. Hold the data stable until resp_ready; then return to IDLE.
- Arbitration: a 1-bit last_grant register.
  - If both requesters are valid, the one not last granted wins.
  - If only one is valid, it wins.
  - last_grant updates only on acceptance.
- req_ready is 0 outside IDLE. There is no queueing; a requester holds valid until it is accepted.
- Register 0 is an ordinary register with no special handling.
- Outside ISSUE/SETTLE, bank address and data outputs hold their last values; strobes are always 0 outside ISSUE.

## Timing
- Cycle A: acceptance (valid & ready in IDLE).
- Cycle A+1: ISSUE.
- Cycle A+2: SETTLE.
- Cycle A+3: resp_valid first high.
- Back-to-back: if resp_ready is high at A+3, the next acceptance can occur at A+4. Throughput is 1 command per 4 cycles.
- A requester may raise a new req_valid while its own response is pending. It is not accepted until the FSM returns to IDLE.
- Reset, sampled at any edge:
  - FSM → IDLE; all strobes, req_ready and resp_valid → 0
  - last_grant → host, so the CPU wins the first tie
  - bank address/data outputs and response data → 0
  - An in-flight command is dropped with no response. A strobe already asserted in ISSUE falls at that edge.

## Structure
- Shared package regbank_pkg:
  - op encodings (OP_READ, OP_WRITE, OP_MOVE, OP_LOADI)
  - state enum
  - WORD_SIZE, REG_ADDR_SIZE, IMM_WIDTH defaults
- One sub-module: rr_arbiter2 (two requests, last_grant register, one-hot grant, update-on-accept input).
- FSM, command latch and response registers stay in regbank_sequencer.

## Test plan
- After reset: all outputs 0; cpu_req_ready=0 until cpu_req_valid rises; the CPU wins the first simultaneous request.
- cpu WRITE rd=5, data=0xDEADBEEF at cycle A → bank_store high only at A+1 with rd_address=5; cpu_resp_valid at A+3 with data 0. Then host READ rs=5, rt=0 → host_resp_rs_data=0xDEADBEEF, rt_data equal to the bank model's reg 0.
- LOADI rd=7, data=0xFFFFFFFF → bank_data_in=0x000FFFFF, bank_load_rd_i one cycle. MOVE rs=3, rt=7 → bank_load_reg_i with rs_address=3, rt_address=7.
- Both requesters valid continuously for 8 commands → grants alternate cpu, host, cpu, …; each response reaches only its owner; strobes are never more than one-hot.
- resp_ready held low for 5 cycles → resp_valid and data stable; the other requester's req_ready stays 0 throughout.
- Reset asserted during ISSUE of a WRITE → strobe low after that edge, no response issued, next acceptance possible on the first cycle after reset deasserts.
